// File: rtl/dac_channel_scheduler.sv
// Round-robin share of one DACx811 driver among NCH slots; grant 1 cycle after pend, transfers serialized by dac_busy.
// Writes are always accepted (coalescing slots); optional post-transfer gap when DAC_SCHED_HOLDOFF_EN is defined.
module dac_channel_scheduler #(
   parameter int NCH     = 4,
   parameter int BITS    = 16,
   parameter int HOLDOFF = 8,
   localparam int SW     = $clog2(NCH)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NCH-1:0]      ch_wr,
   input  logic [NCH*BITS-1:0] ch_data,
   output logic [NCH-1:0]      ch_pend,
   output logic                dac_start,
   output logic [BITS-1:0]     dac_data,
   input  logic                dac_busy,
   output logic [SW-1:0]       dac_sel,
   output logic                done,
   output logic                sched_busy
);

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] WAIT_BUSY = 2'd1;
   localparam logic [1:0] WAIT_DONE = 2'd2;
`ifdef DAC_SCHED_HOLDOFF_EN
   localparam logic [1:0] HOLD      = 2'd3;
   localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
   logic [HW-1:0] hold_cnt;
`endif

   if (NCH < 2 || NCH > 16 || HOLDOFF < 0) begin : g_param_check
      $error("dac_channel_scheduler: NCH must be 2..16 and HOLDOFF >= 0");
   end

   logic [1:0]      state;
   logic [SW-1:0]   last_grant;
   logic [BITS-1:0] slot [NCH];
   logic [SW-1:0]   win;
   logic            found;
   logic [SW:0]     idx;
   logic [NCH-1:0]  grant;

   // First pending slot after the last grant, wrapping NCH-1 -> 0.
   always_comb begin
      win   = last_grant;
      found = 1'b0;
      idx   = '0;
      for (int k = 1; k <= NCH; k++) begin
         idx = {1'b0, last_grant} + (SW+1)'(k);
         if (idx >= (SW+1)'(NCH)) idx = idx - (SW+1)'(NCH);
         if (!found && ch_pend[idx[SW-1:0]]) begin
            found = 1'b1;
            win   = idx[SW-1:0];
         end
      end
   end

   assign grant      = (state == IDLE && found) ? (NCH'(1) << win) : '0;
   assign sched_busy = (state != IDLE);

   // A write in the grant cycle wins over the clear, so the new code stays pending.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ch_pend <= '0;
         for (int i = 0; i < NCH; i++) slot[i] <= '0;
      end else begin
         ch_pend <= (ch_pend & ~grant) | ch_wr;
         for (int i = 0; i < NCH; i++)
            if (ch_wr[i]) slot[i] <= ch_data[i*BITS +: BITS];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= SW'(NCH - 1);
         dac_start  <= 1'b0;
         dac_data   <= '0;
         dac_sel    <= '0;
         done       <= 1'b0;
`ifdef DAC_SCHED_HOLDOFF_EN
         hold_cnt   <= '0;
`endif
      end else begin
         dac_start <= 1'b0;
         done      <= 1'b0;
         case (state)
            IDLE: begin
               if (found) begin
                  dac_start  <= 1'b1;
                  dac_data   <= slot[win];
                  dac_sel    <= win;
                  last_grant <= win;
                  state      <= WAIT_BUSY;
               end
            end
            WAIT_BUSY: begin
               if (dac_busy) state <= WAIT_DONE;
            end
            WAIT_DONE: begin
`ifdef DAC_SCHED_HOLDOFF_EN
               if (!dac_busy) begin
                  done     <= 1'b1;
                  hold_cnt <= '0;
                  state    <= HOLD;
               end
`else
               // Linger one cycle after done so done-to-start spacing matches the HOLDOFF=0 case.
               if (done) state <= IDLE;
               else if (!dac_busy) done <= 1'b1;
`endif
            end
`ifdef DAC_SCHED_HOLDOFF_EN
            HOLD: begin
               if (hold_cnt == HW'(HOLDOFF)) state <= IDLE;
               else hold_cnt <= hold_cnt + 1'b1;
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

endmodule
